lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the data-memory request/response handshake. Accepts one load or store at a time from the core's execute stage, turns it into a word-aligned memory request with byte-lane write mask, waits for the memory response, and returns sign/zero-extended load data. Sits between the miniRV datapath and the `ram` memory model, one request outstanding at most.

## Interface
- `TIMEOUT`, 15: cycles to wait for `memRespValid` after request acceptance before flagging `fault`; 0 disables the watchdog.
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  core request strobe; sampled only when `ready`=1
- `isStore`  in  1  1 = store, 0 = load
- `size`  in  2  `mem_size_t`: 0 byte, 1 half, 2 word; 3 is illegal (treated as misaligned)
- `isUnsigned`  in  1  loads only: zero-extend instead of sign-extend
- `addr`  in  32  byte address
- `storeData`  in  32  store value, low bits significant
- `ready`  out  1  LSU idle, can accept `start`
- `done`  out  1  one-cycle completion pulse
- `loadData`  out  32  extended load result, valid with `done`; 0 for stores
- `misaligned`  out  1  valid with `done`: access rejected, no memory request issued
- `fault`  out  1  valid with `done`: watchdog expired
- `memReqValid`  out  1  request strobe to memory
- `memWen`  out  1  write enable
- `memWdata`  out  32  lane-shifted store data
- `memWbmask`  out  4  byte-lane mask
- `memAddr`  out  32  `{addr[31:2],2'b00}`
- `memBusy`  in  1  memory busy
- `memRespValid`  in  1  one-cycle response pulse
- `memRdata`  in  32  read word, valid with `memRespValid`

## Operation
- FSM `IDLE` → `ISSUE` → `WAIT` → `DONE` → `IDLE`; also `IDLE` → `DONE` for misaligned.
- `IDLE`: `ready`=1. On `start`: register op, size, unsigned, offset `addr[1:0]`, request fields. Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0, size 3) → `DONE` with `misaligned`=1; else → `ISSUE`.
- `ISSUE`: `memReqValid`=1 only if `memBusy`=0; stay until that cycle, then → `WAIT`. `memReqValid` is high for exactly one cycle per request (the memory re-accepts any strobe seen while not busy).
- `WAIT`: on `memRespValid`, capture extended data → `DONE`. Watchdog counts cycles in `WAIT`; reaching `TIMEOUT` → `DONE` with `fault`=1, `loadData`=0.
- `DONE`: `done`=1 for one cycle → `IDLE`.
- Store lanes: byte mask `4'b0001<<off`, data `{4{sd[7:0]}}`; half mask `4'b0011<<off`, data `{2{sd[15:0]}}`; word mask `4'b1111`, data `sd`.
- Load extraction: `w = memRdata >> (8*off)`; byte → `w[7:0]`, half → `w[15:0]`, extended by `isUnsigned`; word → `w`.
- Store completes on `memRespValid` (rdata ignored).
- `memRespValid` outside `WAIT` is ignored; `start` outside `IDLE` is ignored.
- Reset (any state, incl. mid-`WAIT`): → `IDLE`; all outputs 0 except `ready`=1; pending response discarded.

## Timing
- All outputs registered. Reset values: `ready`=1, every other output 0.
- Aligned access against an idle memory (4-count responder): `start` in cycle 0 → `memReqValid` cycle 1 → memory busy cycles 2–5 → `memRespValid` cycle 6 → `done` cycle 7. Latency 7 cycles; `ready` again cycle 8.
- Misaligned: `start` cycle 0 → `done`+`misaligned` cycle 1, no `memReqValid`.
- `memBusy`=1 in `ISSUE` delays `memReqValid` one cycle per busy cycle.
- Back-to-back: next `start` accepted in the cycle `ready` returns.

## Structure
- Shared package `lsu_pkg`: `mem_size_t` (MEM_B, MEM_H, MEM_W), `lsu_state_t`, misalignment and wbmask helper functions.
- Combinational sub-module `lsu_align`: store lane shift/mask and load extract/extend; FSM, watchdog and registers stay in `lsu`.

## Test plan
- sb `addr`=0x1003, `storeData`=0xAB → `memAddr`=0x1000, `memWbmask`=4'b1000, `memWdata`=0xABABABAB, `done` at cycle 7.
- lb `addr`=0x1002 with `memRdata`=0x0080_0000 → `loadData`=0xFFFFFF80; same with lbu → 0x00000080.
- lh `addr`=0x2001 → `done`+`misaligned` in cycle 1, no `memReqValid`; lw `addr`=0x2002 likewise.
- sw `addr`=0x3000, `storeData`=0xDEADBEEF, `memBusy` held 3 extra cycles → single `memReqValid` after busy drops, `memWbmask`=4'b1111.
- Responder never answers, `TIMEOUT`=15 → `done`+`fault` after 15 `WAIT` cycles, `loadData`=0.
- `reset` asserted mid-`WAIT`, late `memRespValid` afterwards → outputs at reset values, no `done`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   mem_size_t  : access width encoding (byte/half/word; 2'd3 is illegal)
//   lsu_state_t : LSU control FSM states
//   is_misaligned(size, off) : 1 when the access cannot be issued
//   wbmask(size, off)        : byte-lane write mask for a store
package lsu_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = off[0];
            MEM_W:   mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] wbmask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            MEM_B:   m = 4'b0001 << off;
            MEM_H:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
//   Store side: st_size_i/st_off_i/store_data_i -> st_wdata_o (lane-replicated
//               data) and st_mask_o (byte-lane write mask).
//   Load side : ld_size_i/ld_off_i/ld_unsigned_i/rdata_i -> ld_data_o
//               (extracted and sign/zero-extended load value).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_mask_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        st_wdata_o = '0;
        case (st_size_i)
            MEM_B:   st_wdata_o = {4{store_data_i[7:0]}};
            MEM_H:   st_wdata_o = {2{store_data_i[15:0]}};
            default: st_wdata_o = store_data_i;
        endcase
        st_mask_o = wbmask(st_size_i, st_off_i);
    end

    always_comb begin
        shifted   = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = '0;
        case (ld_size_i)
            MEM_B:   ld_data_o = ld_unsigned_i ? {24'b0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   ld_data_o = ld_unsigned_i ? {16'b0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory handshake.
// One access outstanding at most.
//   Core side  : start/isStore/size/isUnsigned/addr/storeData in;
//                ready, done (1-cycle pulse), loadData, misaligned, fault out.
//   Memory side: memReqValid/memWen/memWdata/memWbmask/memAddr out;
//                memBusy, memRespValid, memRdata in.
//   TIMEOUT    : WAIT cycles before flagging fault (0 disables the watchdog).
// All outputs are registered; reset is asynchronous, active high.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        isStore,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        ready,
    output logic        done,
    output logic [31:0] loadData,
    output logic        misaligned,
    output logic        fault,
    output logic        memReqValid,
    output logic        memWen,
    output logic [31:0] memWdata,
    output logic [3:0]  memWbmask,
    output logic [31:0] memAddr,
    input  logic        memBusy,
    input  logic        memRespValid,
    input  logic [31:0] memRdata
);

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t  state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [31:0] load_q, load_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;
    logic        req_q, req_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] maddr_q, maddr_d;
    logic        store_q, store_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        ld_uns_q, ld_uns_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_mask;
    logic [31:0] ld_data;

    lsu_align u_align (
        .st_size_i     (size),
        .st_off_i      (addr[1:0]),
        .store_data_i  (storeData),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_uns_q),
        .rdata_i       (memRdata),
        .st_wdata_o    (st_wdata),
        .st_mask_o     (st_mask),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        done_d    = done_q;
        load_d    = load_q;
        mis_d     = mis_q;
        fault_d   = fault_q;
        req_d     = req_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        maddr_d   = maddr_q;
        store_d   = store_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        wd_d      = wd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ready_d   = 1'b0;
                    store_d   = isStore;
                    ld_size_d = size;
                    ld_off_d  = addr[1:0];
                    ld_uns_d  = isUnsigned;
                    if (is_misaligned(size, addr[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        // memReqValid is registered, so the strobe for the
                        // coming ISSUE cycle is qualified by memBusy now.
                        req_d   = ~memBusy;
                        wen_d   = isStore;
                        wdata_d = isStore ? st_wdata : '0;
                        mask_d  = isStore ? st_mask : '0;
                        maddr_d = {addr[31:2], 2'b00};
                    end
                end
            end
            S_ISSUE: begin
                if (req_q) begin
                    req_d   = 1'b0;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end else begin
                    req_d = ~memBusy;
                end
            end
            S_WAIT: begin
                if (memRespValid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    load_d  = store_q ? '0 : ld_data;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    mask_d  = '0;
                    maddr_d = '0;
                end else if (TIMEOUT != 0 && wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    load_d  = '0;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    mask_d  = '0;
                    maddr_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b0;
                mis_d   = 1'b0;
                fault_d = 1'b0;
                load_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            load_q    <= '0;
            mis_q     <= 1'b0;
            fault_q   <= 1'b0;
            req_q     <= 1'b0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= '0;
            maddr_q   <= '0;
            store_q   <= 1'b0;
            ld_size_q <= '0;
            ld_off_q  <= '0;
            ld_uns_q  <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            load_q    <= load_d;
            mis_q     <= mis_d;
            fault_q   <= fault_d;
            req_q     <= req_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            maddr_q   <= maddr_d;
            store_q   <= store_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
            wd_q      <= wd_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign loadData    = load_q;
    assign misaligned  = mis_q;
    assign fault       = fault_q;
    assign memReqValid = req_q;
    assign memWen      = wen_q;
    assign memWdata    = wdata_q;
    assign memWbmask   = mask_q;
    assign memAddr     = maddr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for the LSU: the stimulus pushes expected responses,
// a negedge monitor pops and compares them, and a 4-count memory
// responder answers requests with data chosen by the stimulus.
module tb_lsu;

    localparam int unsigned TO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        isStore = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        isUnsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] storeData = '0;
    logic        ready, done, misaligned, fault;
    logic [31:0] loadData;
    logic        memReqValid, memWen;
    logic [31:0] memWdata, memAddr;
    logic [3:0]  memWbmask;
    logic        memBusy;
    logic        memRespValid = 1'b0;
    logic [31:0] memRdata = '0;

    always #5 clock = ~clock;

    lsu #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .isStore(isStore),
        .size(size), .isUnsigned(isUnsigned), .addr(addr), .storeData(storeData),
        .ready(ready), .done(done), .loadData(loadData), .misaligned(misaligned),
        .fault(fault), .memReqValid(memReqValid), .memWen(memWen),
        .memWdata(memWdata), .memWbmask(memWbmask), .memAddr(memAddr),
        .memBusy(memBusy), .memRespValid(memRespValid), .memRdata(memRdata)
    );

    typedef struct {
        logic [31:0] load;
        bit          mis;
        bit          flt;
        int          lat;
        int          start_cyc;
        bit          st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          noresp;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- memory responder (4 busy cycles, then response) ----
    logic       busy_r = 1'b0;
    logic       hold_busy = 1'b0;
    logic [2:0] cnt = '0;
    logic [31:0] pend = '0;
    rsp_t       rcur;

    assign memBusy = busy_r | hold_busy;

    always @(posedge clock) begin
        memRespValid <= 1'b0;
        memRdata     <= $urandom;
        if (memReqValid && !memBusy) begin
            if (rsp_q.size() > 0) begin
                rcur = rsp_q.pop_front();
                if (!rcur.noresp) begin
                    busy_r <= 1'b1;
                    cnt    <= 3'd3;
                    pend   <= rcur.rdata;
                end
            end
        end else if (busy_r) begin
            if (cnt == 3'd0) begin
                busy_r       <= 1'b0;
                memRespValid <= 1'b1;
                memRdata     <= pend;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // ---------------- reference model ------------------------------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        longint unsigned w, lim;
        int n;
        n   = nbytes(sz);
        w   = longint'(rd) >> (8 * (a % 4));
        lim = 64'd1 << (8 * n);
        w   = w % lim;
        if (n < 4 && !uns && w >= lim / 2) w = w - lim;
        return w[31:0];
    endfunction

    function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m;
        int off;
        m   = '0;
        off = a % 4;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sd[8*(i % nbytes(sz)) +: 8];
        return o;
    endfunction

    // ---------------- monitor --------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    exp_t m;

    always @(negedge clock) begin
        if (reset) begin
            strobes = 0;
            chk("reset_outputs",
                {22'b0, ready, done, misaligned, fault, memReqValid, memWen,
                 |loadData, |memWdata, |memWbmask, |memAddr},
                {22'b0, 1'b1, 9'b0});
        end else begin
            if (memReqValid) begin
                strobes++;
                if (exp_q.size() > 0) begin
                    m = exp_q[0];
                    chk("req_while_busy", {31'b0, memBusy}, 32'd0);
                    chk("memAddr", memAddr, {m.addr[31:2], 2'b00});
                    chk("memWen", {31'b0, memWen}, {31'b0, m.st});
                    if (m.st) begin
                        chk("memWbmask", {28'b0, memWbmask}, {28'b0, m.mask});
                        chk("memWdata", memWdata, m.wdata);
                    end
                end
            end
            if (exp_q.size() == 0) begin
                chk("idle_done", {31'b0, done}, 32'd0);
            end else if (done) begin
                m = exp_q.pop_front();
                chk("loadData", loadData, m.load);
                chk("misaligned", {31'b0, misaligned}, {31'b0, m.mis});
                chk("fault", {31'b0, fault}, {31'b0, m.flt});
                chk("latency", cyc - m.start_cyc, m.lat);
                chk("req_strobes", strobes, m.mis ? 0 : 1);
                strobes = 0;
            end
        end
    end

    // ---------------- stimulus -------------------------------------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1) begin
            @(negedge clock);
            n++;
            if (n > 200) begin
                $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
                $fatal(1, "ready never returned");
            end
        end
    endtask

    task automatic issue(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input bit noresp, input int busy);
        exp_t e;
        rsp_t r;
        wait_ready();
        e.mis       = ref_mis(sz, a);
        e.flt       = !e.mis && noresp;
        e.st        = st;
        e.addr      = a;
        e.mask      = ref_mask(sz, a);
        e.wdata     = ref_wdata(sz, sd);
        e.load      = (e.mis || st || noresp) ? 32'd0 : ref_load(sz, uns, a, rd);
        e.lat       = e.mis ? 1 : (noresp ? 2 + int'(TO) + busy : 7 + busy);
        e.start_cyc = cyc;
        exp_q.push_back(e);
        if (!e.mis) begin
            r.rdata  = rd;
            r.noresp = noresp;
            rsp_q.push_back(r);
        end
        isStore    = st;
        size       = sz;
        isUnsigned = uns;
        addr       = a;
        storeData  = sd;
        start      = 1'b1;
        hold_busy  = (busy > 0);
        @(negedge clock);
        start = 1'b0;
        for (int i = 1; i < busy; i++) @(negedge clock);
        hold_busy = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        issue(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1'b0, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 32'h0080_0000, 1'b0, 0);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_1002, 32'h0, 32'h0080_0000, 1'b0, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_2001, 32'h0, 32'h0, 1'b0, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_2002, 32'h0, 32'h0, 1'b0, 0);
        issue(1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 32'h8001_1234, 1'b0, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b1, 2'd3, 1'b0, 32'h0000_6000, 32'h1234_5678, 32'h0, 1'b0, 0);

        // Reset while the unit sits in WAIT; the late response must be ignored.
        wait_ready();
        rsp_q.push_back('{rdata: 32'h1234_5678, noresp: 1'b0});
        isStore = 1'b0; size = 2'd2; isUnsigned = 1'b0; addr = 32'h40;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (8) @(negedge clock);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(7, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            issue(1'($urandom_range(1, 0)), sz, 1'($urandom_range(1, 0)),
                  $urandom, $urandom, $urandom, 1'b0, int'($urandom_range(2, 0)));
        end

        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clock);
            n++;
            if (n > 300) begin
                $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
                $fatal(1, "responses never arrived");
            end
        end
        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
